// File: rtl/mcycle_controller.sv
// Multi-cycle instruction sequencer: fetch, decode, operand load, execute, memory, writeback, branch.
// Optional macro CTRL_MEM_HANDSHAKE_EN: FETCH/MEM_ACC end on mem_ready instead of a MEM_LAT counter.
module mcycle_controller #(
    parameter int MEM_LAT = 1,
    parameter int FLAG_W  = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [3:0]        op,
    input  logic [3:0]        op_ext,
    input  logic [3:0]        cond,
    input  logic [FLAG_W-1:0] flags,
    input  logic              mem_ready,
    output logic              instr_write,
    output logic              mem_write,
    output logic              reg_write,
    output logic              flag_write,
    output logic              new_alu_input,
    output logic              wb_sel,
    output logic              data_to_write_sel,
    output logic [1:0]        alu_src1_sel,
    output logic [1:0]        alu_src2_sel,
    output logic [1:0]        pc_src,
    output logic              pc_en,
    output logic              illegal,
    output logic [3:0]        state_dbg
);
    typedef enum logic [3:0] {
        FETCH     = 4'd0,
        DECODE    = 4'd1,
        LOAD_OPS  = 4'd2,
        ALU_EX    = 4'd3,
        WRITEBACK = 4'd4,
        MEM_ACC   = 4'd5,
        LOAD_WB   = 4'd6,
        JAL_LINK  = 4'd7,
        BRANCH    = 4'd8,
        PC_INCR   = 4'd9
    } state_t;

    state_t state, nextState;
    logic   accessDone;
    logic   inWait;

    assign inWait = (state == FETCH) || (state == MEM_ACC);

`ifdef CTRL_MEM_HANDSHAKE_EN
    assign accessDone = mem_ready;
`else
    localparam logic [3:0] WAIT_LAST = 4'(MEM_LAT - 1);
    logic [3:0] waitCnt;
    logic       unusedMemReady;

    assign unusedMemReady = mem_ready;
    assign accessDone     = (waitCnt == WAIT_LAST);

    // Counts elapsed cycles of the current memory wait; cleared whenever a wait ends or is left.
    always_ff @(posedge clk) begin
        if (reset) begin
            waitCnt <= '0;
        end else if (inWait && !accessDone) begin
            waitCnt <= waitCnt + 4'd1;
        end else begin
            waitCnt <= '0;
        end
    end
`endif

    // Instruction classes; register ALU ops are selected by op_ext, immediate ALU ops by op.
    logic [3:0] aluCode;
    logic isRegAlu, isImmAlu, isShift, isShiftImm, isLoad, isStor, isJal, isJcond, isBcond;
    logic isAluLike, isMov, isArith, isCmp, useImm;

    assign aluCode    = (op == 4'b0000) ? op_ext : op;
    assign isRegAlu   = (op == 4'b0000) && (op_ext inside {4'b0001, 4'b0010, 4'b0011, 4'b0101, 4'b0110,
                                                           4'b0111, 4'b1001, 4'b1010, 4'b1011, 4'b1101});
    assign isImmAlu   = op inside {4'b0001, 4'b0010, 4'b0011, 4'b0101, 4'b0111,
                                   4'b1001, 4'b1010, 4'b1011, 4'b1101, 4'b1111};
    assign isShift    = (op == 4'b1000) && (op_ext inside {4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0100, 4'b0110});
    assign isShiftImm = isShift && (op_ext[3:2] == 2'b00);
    assign isLoad     = (op == 4'b0100) && (op_ext == 4'b0000);
    assign isStor     = (op == 4'b0100) && (op_ext == 4'b0100);
    assign isJal      = (op == 4'b0100) && (op_ext == 4'b1000);
    assign isJcond    = (op == 4'b0100) && (op_ext == 4'b1100);
    assign isBcond    = (op == 4'b1100);
    assign isAluLike  = isRegAlu || isImmAlu;
    assign isMov      = isAluLike && (aluCode == 4'b1101);
    assign isArith    = isAluLike && (aluCode inside {4'b0101, 4'b0110, 4'b0111, 4'b1001, 4'b1010, 4'b1011});
    assign isCmp      = isAluLike && (aluCode == 4'b1011);
    assign useImm     = isImmAlu || isShiftImm;

    logic flagN, flagZ, flagF, flagL, flagC, condTrue;
    assign {flagN, flagZ, flagF, flagL, flagC} = flags[4:0];

    always_comb begin
        condTrue = 1'b0;
        case (cond)
            4'b0000: condTrue = flagZ;
            4'b0001: condTrue = !flagZ;
            4'b0010: condTrue = flagC;
            4'b0011: condTrue = !flagC;
            4'b0100: condTrue = flagL;
            4'b0101: condTrue = !flagL;
            4'b0110: condTrue = flagN;
            4'b0111: condTrue = !flagN;
            4'b1000: condTrue = flagF;
            4'b1001: condTrue = !flagF;
            4'b1010: condTrue = !flagL && !flagZ;
            4'b1011: condTrue = flagL || flagZ;
            4'b1100: condTrue = !flagN && !flagZ;
            4'b1101: condTrue = flagN || flagZ;
            4'b1110: condTrue = 1'b1;
            default: condTrue = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= FETCH;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState         = state;
        instr_write       = 1'b0;
        mem_write         = 1'b0;
        reg_write         = 1'b0;
        flag_write        = 1'b0;
        new_alu_input     = 1'b0;
        wb_sel            = 1'b0;
        data_to_write_sel = 1'b0;
        alu_src1_sel      = 2'b00;
        alu_src2_sel      = 2'b00;
        pc_src            = 2'b00;
        pc_en             = 1'b0;
        illegal           = 1'b0;
        case (state)
            FETCH: begin
                if (accessDone) begin
                    instr_write = 1'b1;
                    nextState   = DECODE;
                end
            end
            DECODE: begin
                if (isAluLike || isShift || isLoad || isStor || isJal) begin
                    nextState = LOAD_OPS;
                end else if (isBcond || isJcond) begin
                    nextState = BRANCH;
                end else begin
                    illegal   = 1'b1;
                    nextState = PC_INCR;
                end
            end
            LOAD_OPS: begin
                new_alu_input = 1'b1;
                if (isLoad || isStor)  nextState = MEM_ACC;
                else if (isJal)        nextState = JAL_LINK;
                else                   nextState = ALU_EX;
            end
            ALU_EX: begin
                alu_src1_sel = isMov ? 2'b10 : 2'b01;
                alu_src2_sel = useImm ? 2'b01 : 2'b00;
                flag_write   = isArith;
                nextState    = isCmp ? PC_INCR : WRITEBACK;
            end
            WRITEBACK: begin
                reg_write = 1'b1;
                nextState = PC_INCR;
            end
            MEM_ACC: begin
                mem_write = isStor;
                if (accessDone) nextState = isLoad ? LOAD_WB : PC_INCR;
            end
            LOAD_WB: begin
                wb_sel    = 1'b1;
                reg_write = 1'b1;
                nextState = PC_INCR;
            end
            JAL_LINK: begin
                // Link write and jump share one cycle, so the PC must not also be incremented.
                data_to_write_sel = 1'b1;
                reg_write         = 1'b1;
                pc_src            = 2'b01;
                pc_en             = 1'b1;
                nextState         = FETCH;
            end
            BRANCH: begin
                if (condTrue) begin
                    pc_en     = 1'b1;
                    pc_src    = isBcond ? 2'b10 : 2'b01;
                    nextState = FETCH;
                end else begin
                    nextState = PC_INCR;
                end
            end
            PC_INCR: begin
                pc_en     = 1'b1;
                nextState = FETCH;
            end
            default: nextState = FETCH;
        endcase
    end

    assign state_dbg = state;
endmodule

// File: tb/tb_mcycle_controller.sv
// Scoreboard bench for mcycle_controller: a per-instruction cycle model pushes expected outputs, a monitor compares.
module tb_mcycle_controller;
    localparam int MEM_LAT = 3;
    localparam logic [3:0] S_FETCH = 4'd0, S_DECODE = 4'd1, S_LOAD_OPS = 4'd2, S_ALU_EX = 4'd3,
                           S_WRITEBACK = 4'd4, S_MEM_ACC = 4'd5, S_LOAD_WB = 4'd6,
                           S_JAL_LINK = 4'd7, S_BRANCH = 4'd8, S_PC_INCR = 4'd9;

    typedef struct packed {
        logic       iw, mw, rw, fw, nai, wb, dts;
        logic [1:0] s1, s2, ps;
        logic       pe, ill;
        logic [3:0] st;
    } outv_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] op = '0, op_ext = '0, cond = '0;
    logic [4:0] flags = '0;
    logic       mem_ready = 1'b0;
    logic       instr_write, mem_write, reg_write, flag_write, new_alu_input, wb_sel, data_to_write_sel;
    logic [1:0] alu_src1_sel, alu_src2_sel, pc_src;
    logic       pc_en, illegal;
    logic [3:0] state_dbg;

    logic [18:0] exp_q[$];
    string       tag_q[$];
    int          errors = 0;
    int          checks = 0;
    outv_t       act;

    mcycle_controller #(.MEM_LAT(MEM_LAT), .FLAG_W(5)) dut (
        .clk(clk), .reset(reset), .op(op), .op_ext(op_ext), .cond(cond), .flags(flags),
        .mem_ready(mem_ready), .instr_write(instr_write), .mem_write(mem_write), .reg_write(reg_write),
        .flag_write(flag_write), .new_alu_input(new_alu_input), .wb_sel(wb_sel),
        .data_to_write_sel(data_to_write_sel), .alu_src1_sel(alu_src1_sel), .alu_src2_sel(alu_src2_sel),
        .pc_src(pc_src), .pc_en(pc_en), .illegal(illegal), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    assign act = {instr_write, mem_write, reg_write, flag_write, new_alu_input, wb_sel, data_to_write_sel,
                  alu_src1_sel, alu_src2_sel, pc_src, pc_en, illegal, state_dbg};

    // Monitor: every cycle with a pending expectation is compared mid-cycle.
    always @(negedge clk) begin
        outv_t e;
        string t;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            checks++;
            if (act !== e) begin
                errors++;
                $display("FAIL %s: got %b (state %0d) required %b (state %0d) op=%b ext=%b cond=%b flags=%b",
                         t, act, act.st, e, e.st, op, op_ext, cond, flags);
            end
        end
    end

    function automatic outv_t idle(input logic [3:0] st);
        outv_t v;
        v    = '0;
        v.st = st;
        return v;
    endfunction

    function automatic bit cond_true(input logic [3:0] c, input logic [4:0] f);
        bit n, z, fl, l, cy, base;
        {n, z, fl, l, cy} = f;
        case (c[3:1])
            3'd0: base = z;
            3'd1: base = cy;
            3'd2: base = l;
            3'd3: base = n;
            3'd4: base = fl;
            3'd5: base = !l && !z;
            3'd6: base = !n && !z;
            default: base = 1'b1;
        endcase
        return c[0] ? !base : base;
    endfunction

    function automatic logic rnd_ready();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic step(input outv_t v, input string t, input logic mr);
        mem_ready = mr;
        exp_q.push_back(v);
        tag_q.push_back(t);
        @(posedge clk);
        #1;
    endtask

    // A memory wait (FETCH or MEM_ACC); its length comes from MEM_LAT or from when mem_ready is raised.
    task automatic do_wait(input logic [3:0] st, input bit stor, input string t, input int forceN);
        int n;
        outv_t v;
`ifdef CTRL_MEM_HANDSHAKE_EN
        n = (forceN > 0) ? forceN : int'($urandom_range(1, 6));
`else
        n = MEM_LAT;
`endif
        for (int k = 1; k <= n; k++) begin
            v    = idle(st);
            v.mw = stor;
            v.iw = (st == S_FETCH) && (k == n);
`ifdef CTRL_MEM_HANDSHAKE_EN
            step(v, t, k == n);
`else
            step(v, t, rnd_ready());
`endif
        end
    endtask

    task automatic pc_incr();
        outv_t v;
        v    = idle(S_PC_INCR);
        v.pe = 1'b1;
        step(v, "pc_incr", rnd_ready());
    endtask

    // Reference sequence for one instruction, from instruction class to per-cycle outputs.
    task automatic run_instr(input logic [3:0] o, input logic [3:0] e, input logic [3:0] c,
                             input logic [4:0] f, input int memN);
        outv_t v;
        bit regAlu, immAlu, shift, ld, stor, jal, jc, bc, aluLike, legal;
        logic [3:0] code;
        op = o; op_ext = e; cond = c; flags = f;
        regAlu  = (o == 4'd0) && (e inside {4'd1, 4'd2, 4'd3, 4'd5, 4'd6, 4'd7, 4'd9, 4'd10, 4'd11, 4'd13});
        immAlu  = o inside {4'd1, 4'd2, 4'd3, 4'd5, 4'd7, 4'd9, 4'd10, 4'd11, 4'd13, 4'd15};
        shift   = (o == 4'd8) && (e inside {4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd6});
        ld      = (o == 4'd4) && (e == 4'd0);
        stor    = (o == 4'd4) && (e == 4'd4);
        jal     = (o == 4'd4) && (e == 4'd8);
        jc      = (o == 4'd4) && (e == 4'd12);
        bc      = (o == 4'd12);
        aluLike = regAlu || immAlu;
        legal   = aluLike || shift || ld || stor || jal || jc || bc;
        code    = regAlu ? e : o;

        do_wait(S_FETCH, 1'b0, "fetch", 0);
        v     = idle(S_DECODE);
        v.ill = !legal;
        step(v, "decode", rnd_ready());
        if (!legal) begin
            pc_incr();
            return;
        end
        if (jc || bc) begin
            v = idle(S_BRANCH);
            if (cond_true(c, f)) begin
                v.pe = 1'b1;
                v.ps = bc ? 2'b10 : 2'b01;
                step(v, "branch_taken", rnd_ready());
            end else begin
                step(v, "branch_not_taken", rnd_ready());
                pc_incr();
            end
            return;
        end
        v     = idle(S_LOAD_OPS);
        v.nai = 1'b1;
        step(v, "load_ops", rnd_ready());
        if (ld || stor) begin
            do_wait(S_MEM_ACC, stor, "mem_acc", memN);
            if (ld) begin
                v    = idle(S_LOAD_WB);
                v.wb = 1'b1;
                v.rw = 1'b1;
                step(v, "load_wb", rnd_ready());
            end
            pc_incr();
        end else if (jal) begin
            v     = idle(S_JAL_LINK);
            v.dts = 1'b1;
            v.rw  = 1'b1;
            v.ps  = 2'b01;
            v.pe  = 1'b1;
            step(v, "jal_link", rnd_ready());
        end else begin
            v    = idle(S_ALU_EX);
            v.s1 = (aluLike && code == 4'd13) ? 2'b10 : 2'b01;
            v.s2 = (immAlu || (shift && e < 4'd4)) ? 2'b01 : 2'b00;
            v.fw = aluLike && (code inside {4'd5, 4'd6, 4'd7, 4'd9, 4'd10, 4'd11});
            step(v, "alu_ex", rnd_ready());
            if (!(aluLike && code == 4'd11)) begin
                v    = idle(S_WRITEBACK);
                v.rw = 1'b1;
                step(v, "writeback", rnd_ready());
            end
            pc_incr();
        end
    endtask

    // STOR interrupted by reset in its second MEM_ACC cycle.
    task automatic stor_reset();
        outv_t v;
        op = 4'd4; op_ext = 4'd4; cond = 4'd0; flags = 5'($urandom_range(0, 31));
        do_wait(S_FETCH, 1'b0, "fetch", 0);
        step(idle(S_DECODE), "stor_decode", 1'b0);
        v     = idle(S_LOAD_OPS);
        v.nai = 1'b1;
        step(v, "stor_load_ops", 1'b0);
        v    = idle(S_MEM_ACC);
        v.mw = 1'b1;
        step(v, "stor_acc1", 1'b0);
        reset = 1'b1;
        step(v, "stor_acc2_reset", 1'b0);
        step(idle(S_FETCH), "after_reset_fetch", 1'b0);
        reset = 1'b0;
    endtask

    initial begin
        @(posedge clk);
        #1;
        step(idle(S_FETCH), "reset_state", 1'b0);
        step(idle(S_FETCH), "reset_state_hold", 1'b0);
        reset = 1'b0;

        run_instr(4'b0000, 4'b0101, 4'd0, 5'd0, 0);
        run_instr(4'b1100, 4'd3, 4'b0000, 5'b01000, 0);
        run_instr(4'b1100, 4'd3, 4'b0000, 5'b10111, 0);
        for (int c = 0; c < 16; c++) begin
            for (int f = 0; f < 32; f++) begin
                run_instr(4'b0100, 4'b1100, 4'(c), 5'(f), 0);
            end
        end
        run_instr(4'b0100, 4'b0000, 4'd0, 5'd0, 5);
        run_instr(4'b0100, 4'b0100, 4'd0, 5'd0, 0);
        run_instr(4'b0100, 4'b1000, 4'd0, 5'd0, 0);
        run_instr(4'b0000, 4'b1011, 4'd0, 5'd0, 0);
        run_instr(4'b1011, 4'd0, 4'd0, 5'd0, 0);
        run_instr(4'b1101, 4'd0, 4'd0, 5'd0, 0);
        run_instr(4'b0000, 4'b1101, 4'd0, 5'd0, 0);
        run_instr(4'b1000, 4'b0000, 4'd0, 5'd0, 0);
        run_instr(4'b1000, 4'b0100, 4'd0, 5'd0, 0);
        run_instr(4'b0000, 4'b0001, 4'd0, 5'd0, 0);
        stor_reset();
        run_instr(4'b0110, 4'd0, 4'd0, 5'd0, 0);
        for (int i = 0; i < 300; i++) begin
            run_instr(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                      4'($urandom_range(0, 15)), 5'($urandom_range(0, 31)), 0);
        end

        @(negedge clk);
        @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expectations, required 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        errors++;
        checks++;
        $display("FAIL watchdog: got timeout, required completion");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mcycle_controller.md
MCYCLE_CONTROLLER -- requirements
Module: mcycle_controller

Interface
REQ-001 Parameter MEM_LAT, default 1, number of wait cycles (1..15) a memory access is held in FETCH/MEM_ACC; 0 is illegal.
REQ-002 Parameter FLAG_W, default 5, width of flags bus; bit order {N,Z,F,L,C} from MSB to LSB; FLAG_W < 5 is illegal.
REQ-003 clk  in  1  single clock; all state changes on rising edge.
REQ-004 reset  in  1  synchronous, active-high.
REQ-005 op, op_ext, cond  in  4 each  instruction fields from instruction register.
REQ-006 flags  in  FLAG_W  processor status flags; only bits [4:0] are used.
REQ-007 mem_ready  in  1  memory access-complete strobe (used only with CTRL_MEM_HANDSHAKE_EN).
REQ-008 instr_write, mem_write, reg_write, flag_write, new_alu_input  out  1 each  enables, active-high.
REQ-009 wb_sel, data_to_write_sel  out  1 each  0=ALU result / 1=memory data; 0=writeback mux / 1=PC link value.
REQ-010 alu_src1_sel, alu_src2_sel  out  2 each  00=PC/const, 01=register/immediate, 10=zero.
REQ-011 pc_src  out  2  00=PC+1, 01=register (Jcond/JAL), 10=PC+sign-extended displacement (Bcond).
REQ-012 pc_en  out  1  PC load enable.
REQ-013 illegal  out  1  one-cycle pulse on undecodable instruction.
REQ-014 state_dbg  out  4  current state encoding.

Function
REQ-015 States: FETCH, DECODE, LOAD_OPS, ALU_EX, WRITEBACK, MEM_ACC, LOAD_WB, JAL_LINK, BRANCH, PC_INCR.
REQ-016 FETCH asserts instr_write in its final wait cycle only, then goes to DECODE.
REQ-017 DECODE: ALU reg/imm ops, shifts, CMP/CMPI, MOV/MOVI, LOAD, STOR, JAL -> LOAD_OPS; Bcond (op=1100) and Jcond (op=0100, op_ext=1100) -> BRANCH; anything else -> PC_INCR with illegal=1.
REQ-018 LOAD_OPS asserts new_alu_input for 1 cycle; -> ALU_EX, or MEM_ACC for LOAD/STOR, or JAL_LINK for JAL.
REQ-019 ALU_EX drives alu_src1_sel=01 (10 for MOV/MOVI), alu_src2_sel=01 for immediate forms; flag_write=1 for ADD/SUB/CMP forms only; CMP/CMPI -> PC_INCR, others -> WRITEBACK.
REQ-020 WRITEBACK asserts reg_write for 1 cycle -> PC_INCR.
REQ-021 MEM_ACC holds; STOR asserts mem_write in every MEM_ACC cycle; on completion LOAD -> LOAD_WB (wb_sel=1, reg_write=1), STOR -> PC_INCR.
REQ-022 JAL_LINK: data_to_write_sel=1, reg_write=1, pc_src=01, pc_en=1 in same cycle -> FETCH (no PC_INCR).
REQ-023 BRANCH evaluates cond: 0000 Z; 0001 !Z; 0010 C; 0011 !C; 0100 L; 0101 !L; 0110 N; 0111 !N; 1000 F; 1001 !F; 1010 !L&!Z; 1011 L|Z; 1100 !N&!Z; 1101 N|Z; 1110 true; 1111 false.
REQ-024 BRANCH taken: pc_en=1, pc_src=10 (Bcond) or 01 (Jcond) -> FETCH; not taken: pc_en=0 -> PC_INCR.
REQ-025 PC_INCR: pc_en=1, pc_src=00 -> FETCH.
REQ-026 All outputs are combinational from state (and flags/cond in BRANCH); every output is 0 in any state not asserting it.
REQ-027 Flags sampled in BRANCH cycle only; a flag_write in the prior instruction is visible.
REQ-028 Unreachable state encodings -> FETCH next cycle, all outputs 0.

Reset
REQ-029 reset=1 at rising edge: state=FETCH, wait counter=0, regardless of current state, including mid MEM_ACC (mem_write drops next cycle).
REQ-030 During/after reset all outputs 0 except state_dbg=FETCH encoding.

Configuration
REQ-031 Macro CTRL_MEM_HANDSHAKE_EN defined: FETCH/MEM_ACC complete on first cycle with mem_ready=1 (min 1 cycle), MEM_LAT ignored.
REQ-032 Macro undefined: FETCH/MEM_ACC complete after exactly MEM_LAT cycles via internal counter; mem_ready ignored.

Verification
REQ-033 Reset then ADD (op=0000, op_ext=0101), MEM_LAT=1 -> FETCH,DECODE,LOAD_OPS,ALU_EX(flag_write=1),WRITEBACK(reg_write=1),PC_INCR(pc_en=1): 6 cycles.
REQ-034 Bcond cond=0000, flags Z=1 -> BRANCH pc_en=1 pc_src=10, next FETCH; repeat with Z=0 -> PC_INCR then FETCH.
REQ-035 All 16 cond codes x 32 flag combinations via Jcond -> pc_en matches REQ-023 table, pc_src=01 when taken.
REQ-036 LOAD, MEM_LAT=3 (macro off) -> MEM_ACC 3 cycles, LOAD_WB wb_sel=1 reg_write=1; macro on, mem_ready at 5th cycle -> 5 MEM_ACC cycles.
REQ-037 STOR, reset asserted 2nd MEM_ACC cycle -> mem_write=0 next cycle, state FETCH.
REQ-038 op=0110 -> illegal=1 in DECODE, PC_INCR, no reg_write/mem_write.
